uart_tx_from_fifo: RTL and testbench
====================================

Name: uart_tx_from_fifo

Overview:
- Serial UART transmitter that drains the 8-bit FIFO on the training board's host-return path.
- Consumes the FIFO's first-word-fall-through read port: the head word is valid on the FIFO data output whenever its empty flag is low, and a one-cycle re pops it.
- Each byte popped is emitted on txd as one asynchronous frame: start bit, 8 data bits LSB-first, optional parity bit, 1 stop bit.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); must be >= 2.
- CNT_WIDTH, 10, width of the baud counter; must satisfy 2^CNT_WIDTH >= CLKS_PER_BIT.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- tx_en  input  1  permits starting a new frame; sampled only in IDLE.
- fifo_data  input  8  head word from FIFO; valid while fifo_empty = 0.
- fifo_empty  input  1  FIFO empty flag.
- fifo_re  output  1  FIFO pop strobe, single-cycle.
- txd  output  1  serial line, idle high.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset values, applied asynchronously: state IDLE, txd = 1, baud counter 0, bit index 0, shift register 0, parity accumulator 0. Consequently busy = 0 and fifo_re = 0.
- States: IDLE, START, DATA, PAR, STOP.
- fifo_re is combinational: fifo_re = (state == IDLE) & tx_en & ~fifo_empty.
  - In the same cycle, the clock edge captures fifo_data into the shift register, clears the baud counter, and moves to START.
  - Exactly one pop per frame.
  - The FIFO's empty flag lags by one cycle. Because the block has already left IDLE, that lag cannot cause a double pop.
- txd is registered. It drives 0 from the edge that enters START, so txd falls exactly 1 clk after the fifo_re cycle.
- Every non-IDLE state holds its txd value for exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1, and the state advances on the cycle where counter == CLKS_PER_BIT-1.
- START → DATA, txd = shift[0].
- DATA:
  - At each bit end, shift right and increment the bit index.
  - After bit index 7 completes, go to PAR if PARITY != 0, else STOP.
- PAR: txd = ^data for even parity, ~^data for odd parity, computed over the captured byte.
- STOP: txd = 1. At bit end → IDLE.
- Frame length: 10 × CLKS_PER_BIT cycles (11 × with parity).
- Back-to-back frames: if the FIFO is non-empty and tx_en = 1 on return to IDLE, the pop happens in that first IDLE cycle. The gap between frames is therefore exactly 1 extra high clk after the stop bit; no other idle insertion.
- tx_en deasserted mid-frame: the current frame completes normally, then the block stays in IDLE.
- fifo_empty / fifo_data changes mid-frame: ignored (the data is latched).
- Reset asserted mid-frame: txd returns to 1 immediately (asynchronous) and the frame is abandoned. No pop occurs until reset is released and the IDLE conditions hold.
- PARITY values other than 0, 1, 2 behave as 0.

Test Plan:
- Single frame, CLKS_PER_BIT=4, PARITY=0, FIFO holds 0xA5, tx_en=1:
  - fifo_re high for exactly 1 clk.
  - Next clk txd=0 for 4 clks.
  - Then txd shows 1,0,1,0,0,1,0,1 (4 clks each).
  - Then stop = 1 for 4 clks; busy high for 40 clks, then low.
- Back-to-back, FIFO holds 0x00 then 0xFF, CLKS_PER_BIT=4:
  - Two fifo_re pulses exactly 41 clks apart.
  - Second start bit begins 1 clk after the first stop bit ends.
  - No third pop once fifo_empty=1.
- Empty / disabled:
  - fifo_empty=1 with tx_en=1 for 100 clks → fifo_re never asserted, txd stays 1.
  - fifo_empty=0 with tx_en=0 → same result.
- Parity, CLKS_PER_BIT=4, byte 0x01:
  - PARITY=1 → parity bit = 1.
  - PARITY=2 → parity bit = 0.
  - In both cases the frame is 44 clks and the stop bit follows the parity bit.
- tx_en dropped at clk 10 of a frame: the frame completes with the full 40-clk waveform, then no further pops while the FIFO is still non-empty.
- rst_n pulsed low at clk 15 of a frame:
  - txd=1 and busy=0 immediately.
  - After release with the FIFO non-empty, the next fifo_re occurs on the first clk edge with tx_en=1, starting a fresh frame with a full start bit.

Source files
------------

// File: rtl/uart_tx_from_fifo.sv
// UART transmitter that drains a first-word-fall-through FIFO, one frame per popped byte.
// Frame: start bit, 8 data bits LSB-first, optional even/odd parity bit, one stop bit.
module uart_tx_from_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_WIDTH    = 10,
    parameter int PARITY       = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_re,
    output logic       txd,
    output logic       busy
);

    localparam logic [CNT_WIDTH-1:0] BIT_LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic PAR_EN  = (PARITY == 1) || (PARITY == 2);
    localparam logic PAR_ODD = (PARITY == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] baud_cnt;
    logic [2:0]           bit_idx;
    logic [7:0]           shift;
    logic                 par_acc;
    logic                 bit_end;
    logic                 par_next;

    assign bit_end  = (baud_cnt == BIT_LAST);
    assign par_next = par_acc ^ shift[0];
    assign busy     = (state != IDLE);

    // Gated by rst_n so a FIFO outside this reset domain is never popped while held in reset.
    assign fifo_re = rst_n & (state == IDLE) & tx_en & ~fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            txd      <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shift    <= 8'h00;
            par_acc  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    txd      <= 1'b1;
                    baud_cnt <= '0;
                    if (fifo_re) begin
                        shift   <= fifo_data;
                        par_acc <= 1'b0;
                        bit_idx <= 3'd0;
                        txd     <= 1'b0;
                        state   <= START;
                    end
                end

                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        txd      <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        par_acc  <= par_next;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= 3'd0;
                            if (PAR_EN) begin
                                txd   <= par_next ^ PAR_ODD;
                                state <= PAR;
                            end else begin
                                txd   <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            txd     <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                PAR: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        txd      <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        txd      <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    baud_cnt <= '0;
                    txd      <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_from_fifo.sv
// Bench for uart_tx_from_fifo: four instances (PARITY 0..3) share one FIFO model, selected by sel.
// Expected waveforms come from a frame model built from bit counts and byte arithmetic.
module tb_uart_tx_from_fifo;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tx_en = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [7:0] fifo_data_m = 8'h00;
    logic       fifo_empty_m = 1'b1;
    logic [3:0] en_v, empty_v, re_v, txd_v, busy_v;
    logic       re, txd, busy;
    logic [7:0] q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         last_pop = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        assign en_v[g]    = tx_en & (sel == 2'(g));
        assign empty_v[g] = (sel == 2'(g)) ? fifo_empty_m : 1'b1;
        uart_tx_from_fifo #(.CLKS_PER_BIT(CPB), .CNT_WIDTH(2), .PARITY(g)) dut (
            .clk(clk), .rst_n(rst_n), .tx_en(en_v[g]), .fifo_data(fifo_data_m),
            .fifo_empty(empty_v[g]), .fifo_re(re_v[g]), .txd(txd_v[g]), .busy(busy_v[g])
        );
    end

    assign re   = re_v[sel];
    assign txd  = txd_v[sel];
    assign busy = busy_v[sel];

    function automatic void refresh();
        fifo_empty_m = (q.size() == 0);
        fifo_data_m  = (q.size() != 0) ? q[0] : 8'h00;
    endfunction

    // FIFO model: pops on the edge that sees the strobe, head/empty update half a cycle later.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (re === 1'b1 && q.size() != 0) void'(q.pop_front());
    end

    always @(negedge clk) refresh();

    function automatic int frameBits(input int mode);
        return (mode == 1 || mode == 2) ? 11 : 10;
    endfunction

    function automatic logic frameBit(input logic [7:0] d, input int mode, input int idx);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += (d >> i) & 1;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (idx == 9 && mode == 1) return 1'((ones % 2));
        if (idx == 9 && mode == 2) return 1'(1 - (ones % 2));
        return 1'b1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input int n, input logic [7:0] b0, input logic [7:0] b1);
        if (n >= 1) q.push_back(b0);
        if (n >= 2) q.push_back(b1);
        for (int i = 2; i < n; i++) q.push_back(8'($urandom));
        refresh();
        tx_en = en;
    endtask

    task automatic runFrame(input string tag, input int drop_at, input int exp_gap);
        logic [7:0] d;
        int         nb;
        int         mode;
        int         waited;
        mode   = int'(sel);
        waited = 0;
        #1;
        while (re !== 1'b1 && waited < 300) begin
            @(negedge clk); #1;
            waited++;
        end
        checkOutput({tag, " pop strobe"}, 32'(re), 32'd1);
        if (re === 1'b1 && q.size() != 0) begin
            if (exp_gap >= 0) checkOutput({tag, " pop spacing"}, 32'(cyc - last_pop), 32'(exp_gap));
            last_pop = cyc;
            d = q[0];
            checkOutput({tag, " txd idle at pop"}, 32'(txd), 32'd1);
            nb = frameBits(mode);
            for (int k = 0; k < nb * CPB; k++) begin
                @(negedge clk);
                if (k == drop_at) tx_en = 1'b0;
                #1;
                checkOutput($sformatf("%s txd bit %0d", tag, k / CPB), 32'(txd), 32'(frameBit(d, mode, k / CPB)));
                checkOutput({tag, " busy in frame"}, 32'(busy), 32'd1);
                checkOutput({tag, " no pop in frame"}, 32'(re), 32'd0);
            end
            @(negedge clk); #1;
            checkOutput({tag, " busy after frame"}, 32'(busy), 32'd0);
            checkOutput({tag, " txd after frame"}, 32'(txd), 32'd1);
        end
    endtask

    task automatic idleWatch(input string tag, input int ncyc, input int exp_q);
        logic seen_re;
        logic seen_low;
        logic seen_busy;
        seen_re   = 1'b0;
        seen_low  = 1'b0;
        seen_busy = 1'b0;
        repeat (ncyc) begin
            @(negedge clk); #1;
            if (re !== 1'b0) seen_re = 1'b1;
            if (txd !== 1'b1) seen_low = 1'b1;
            if (busy !== 1'b0) seen_busy = 1'b1;
        end
        checkOutput({tag, " pop seen"}, 32'(seen_re), 32'd0);
        checkOutput({tag, " txd low seen"}, 32'(seen_low), 32'd0);
        checkOutput({tag, " busy seen"}, 32'(seen_busy), 32'd0);
        checkOutput({tag, " fifo depth"}, 32'(q.size()), 32'(exp_q));
    endtask

    initial begin
        int gap;

        // Reset held with a ready FIFO: nothing may pop, all lines idle.
        #2 rst_n = 1'b0;
        applyStimulus(1'b1, 1, 8'h55, 8'h00);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset txd all", 32'(txd_v), 32'hF);
        checkOutput("reset busy all", 32'(busy_v), 32'h0);
        checkOutput("reset fifo_re all", 32'(re_v), 32'h0);
        checkOutput("reset fifo depth", 32'(q.size()), 32'd1);
        rst_n = 1'b1;
        runFrame("release 0x55", -1, -1);

        applyStimulus(1'b1, 1, 8'hA5, 8'h00);
        runFrame("single 0xA5", -1, -1);
        idleWatch("after 0xA5", 20, 0);

        applyStimulus(1'b1, 2, 8'h00, 8'hFF);
        runFrame("b2b 0x00", -1, -1);
        runFrame("b2b 0xFF", -1, 41);
        idleWatch("no third pop", 30, 0);

        tx_en = 1'b1;
        idleWatch("empty enabled", 100, 0);
        applyStimulus(1'b0, 1, 8'h81, 8'h00);
        idleWatch("disabled", 100, 1);
        tx_en = 1'b1;
        runFrame("disabled drain", -1, -1);

        sel = 2'd1;
        applyStimulus(1'b1, 1, 8'h01, 8'h00);
        runFrame("even 0x01", -1, -1);
        sel = 2'd2;
        applyStimulus(1'b1, 1, 8'h01, 8'h00);
        runFrame("odd 0x01", -1, -1);

        sel = 2'd0;
        applyStimulus(1'b1, 3, 8'($urandom), 8'($urandom));
        runFrame("tx_en drop", 10, -1);
        idleWatch("after drop", 50, 2);
        q.delete();
        refresh();

        // Reset in the middle of a frame abandons it; the next byte goes out after release.
        applyStimulus(1'b1, 2, 8'h3C, 8'($urandom));
        #1;
        checkOutput("midreset pop", 32'(re), 32'd1);
        repeat (15) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset txd", 32'(txd), 32'd1);
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset fifo_re", 32'(re), 32'd0);
        @(negedge clk); #1;
        checkOutput("midreset held txd", 32'(txd), 32'd1);
        checkOutput("midreset held fifo_re", 32'(re), 32'd0);
        checkOutput("midreset fifo depth", 32'(q.size()), 32'd1);
        rst_n = 1'b1;
        runFrame("after reset", -1, -1);
        idleWatch("after reset idle", 10, 0);

        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            gap = frameBits(s) * CPB + 1;
            applyStimulus(1'b1, 3, 8'($urandom), 8'($urandom));
            runFrame($sformatf("rand p%0d f0", s), -1, -1);
            runFrame($sformatf("rand p%0d f1", s), -1, gap);
            runFrame($sformatf("rand p%0d f2", s), -1, gap);
            idleWatch($sformatf("rand p%0d drained", s), 10, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
